// File: rtl/shk_rr_scheduler.sv
// Four-requester round-robin scheduler for one shared shake-bus target.
// Holds a grant for a full four-phase transaction, registers the request
// payload toward the target, routes the response back combinationally and
// aborts stalled transactions with a watchdog, recording them in a sticky
// error word.
//
// state  | meaning
// S_IDLE | no grant; arbitrate from r_ptr
// S_REQ  | dst_valid high, waiting for dst_ready
// S_ACK  | dst_ready seen, waiting for granted src_valid to drop
// S_DONE | dst_valid low, waiting for dst_ready to drop
module shk_rr_scheduler #(
    parameter int MD_SIM_ABLE  = 0,
    parameter int WD_SHK0_DATA = 16,
    parameter int WD_SHK0_ADDR = 16,
    parameter int WD_ERR_INFO  = 4,
    parameter int TM_TIMEOUT   = 1024
) (
    input  logic                    i_sys_clk,
    input  logic                    i_sys_resetn,
    input  logic                    s_shk_0_src_valid,
    input  logic                    s_shk_0_src_msync,
    input  logic [WD_SHK0_DATA-1:0] s_shk_0_src_mdata,
    input  logic [WD_SHK0_ADDR-1:0] s_shk_0_src_maddr,
    output logic                    s_shk_0_src_ready,
    output logic                    s_shk_0_src_ssync,
    output logic [WD_SHK0_DATA-1:0] s_shk_0_src_sdata,
    output logic [WD_SHK0_ADDR-1:0] s_shk_0_src_saddr,
    input  logic                    s_shk_1_src_valid,
    input  logic                    s_shk_1_src_msync,
    input  logic [WD_SHK0_DATA-1:0] s_shk_1_src_mdata,
    input  logic [WD_SHK0_ADDR-1:0] s_shk_1_src_maddr,
    output logic                    s_shk_1_src_ready,
    output logic                    s_shk_1_src_ssync,
    output logic [WD_SHK0_DATA-1:0] s_shk_1_src_sdata,
    output logic [WD_SHK0_ADDR-1:0] s_shk_1_src_saddr,
    input  logic                    s_shk_2_src_valid,
    input  logic                    s_shk_2_src_msync,
    input  logic [WD_SHK0_DATA-1:0] s_shk_2_src_mdata,
    input  logic [WD_SHK0_ADDR-1:0] s_shk_2_src_maddr,
    output logic                    s_shk_2_src_ready,
    output logic                    s_shk_2_src_ssync,
    output logic [WD_SHK0_DATA-1:0] s_shk_2_src_sdata,
    output logic [WD_SHK0_ADDR-1:0] s_shk_2_src_saddr,
    input  logic                    s_shk_3_src_valid,
    input  logic                    s_shk_3_src_msync,
    input  logic [WD_SHK0_DATA-1:0] s_shk_3_src_mdata,
    input  logic [WD_SHK0_ADDR-1:0] s_shk_3_src_maddr,
    output logic                    s_shk_3_src_ready,
    output logic                    s_shk_3_src_ssync,
    output logic [WD_SHK0_DATA-1:0] s_shk_3_src_sdata,
    output logic [WD_SHK0_ADDR-1:0] s_shk_3_src_saddr,
    output logic                    m_shk_0_dst_valid,
    output logic                    m_shk_0_dst_msync,
    output logic [WD_SHK0_DATA-1:0] m_shk_0_dst_mdata,
    output logic [WD_SHK0_ADDR-1:0] m_shk_0_dst_maddr,
    input  logic                    m_shk_0_dst_ready,
    input  logic                    m_shk_0_dst_ssync,
    input  logic [WD_SHK0_DATA-1:0] m_shk_0_dst_sdata,
    input  logic [WD_SHK0_ADDR-1:0] m_shk_0_dst_saddr,
    input  logic                    i_err_clr,
    output logic [WD_ERR_INFO-1:0]  m_err_shk_info1
);

    localparam int WD_CNT = $clog2(TM_TIMEOUT);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_ACK, S_DONE} state_t;

    state_t                  state, state_nxt;
    logic [1:0]              r_ptr, ptr_nxt;
    logic [1:0]              r_grant, grant_nxt;
    logic [WD_CNT-1:0]       r_cnt;
    logic                    timeout;
    logic                    dst_valid_nxt;
    logic                    load;
    logic                    err_rdy, err_rel;
    logic [1:0]              r_err_bits, r_err_idx;
    logic                    pick_hit;
    logic [1:0]              pick_idx, cand;
    logic                    rsp_en;
    logic [3:0]              sel;

    logic [3:0]              src_valid, src_msync;
    logic [WD_SHK0_DATA-1:0] src_mdata [4];
    logic [WD_SHK0_ADDR-1:0] src_maddr [4];

    // Simulation mode carries no behaviour in this block.
    if (MD_SIM_ABLE != 0) begin : g_sim_mode
    end

    assign src_valid    = {s_shk_3_src_valid, s_shk_2_src_valid, s_shk_1_src_valid, s_shk_0_src_valid};
    assign src_msync    = {s_shk_3_src_msync, s_shk_2_src_msync, s_shk_1_src_msync, s_shk_0_src_msync};
    assign src_mdata[0] = s_shk_0_src_mdata;
    assign src_mdata[1] = s_shk_1_src_mdata;
    assign src_mdata[2] = s_shk_2_src_mdata;
    assign src_mdata[3] = s_shk_3_src_mdata;
    assign src_maddr[0] = s_shk_0_src_maddr;
    assign src_maddr[1] = s_shk_1_src_maddr;
    assign src_maddr[2] = s_shk_2_src_maddr;
    assign src_maddr[3] = s_shk_3_src_maddr;

    assign timeout = (r_cnt == WD_CNT'(TM_TIMEOUT - 1));

    // Round-robin pick: first pending requester at or after r_ptr.
    always_comb begin
        pick_hit = 1'b0;
        pick_idx = r_ptr;
        cand     = r_ptr;
        for (int i = 0; i < 4; i++) begin
            cand = r_ptr + 2'(i);
            if (!pick_hit && src_valid[cand]) begin
                pick_hit = 1'b1;
                pick_idx = cand;
            end
        end
    end

    // Next-state, grant/pointer update, dst_valid and error events.
    always_comb begin
        state_nxt     = state;
        grant_nxt     = r_grant;
        ptr_nxt       = r_ptr;
        dst_valid_nxt = m_shk_0_dst_valid;
        load          = 1'b0;
        err_rdy       = 1'b0;
        err_rel       = 1'b0;
        case (state)
            S_IDLE: begin
                dst_valid_nxt = 1'b0;
                if (pick_hit) begin
                    grant_nxt     = pick_idx;
                    load          = 1'b1;
                    dst_valid_nxt = 1'b1;
                    state_nxt     = S_REQ;
                end
            end
            S_REQ: begin
                if (m_shk_0_dst_ready) begin
                    state_nxt = S_ACK;
                end else if (timeout) begin
                    dst_valid_nxt = 1'b0;
                    err_rdy       = 1'b1;
                    state_nxt     = S_DONE;
                end
            end
            S_ACK: begin
                if (!src_valid[r_grant]) begin
                    dst_valid_nxt = 1'b0;
                    state_nxt     = S_DONE;
                end
            end
            S_DONE: begin
                dst_valid_nxt = 1'b0;
                if (!m_shk_0_dst_ready || timeout) begin
                    err_rel   = m_shk_0_dst_ready;
                    ptr_nxt   = r_grant + 2'd1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // State, pointer, grant and watchdog registers.
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            state   <= S_IDLE;
            r_ptr   <= 2'd0;
            r_grant <= 2'd0;
            r_cnt   <= '0;
        end else begin
            state   <= state_nxt;
            r_ptr   <= ptr_nxt;
            r_grant <= grant_nxt;
            if (state_nxt != state) begin
                r_cnt <= '0;
            end else if (state == S_REQ || state == S_DONE) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    // Registered request toward the target; payload captured at grant.
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            m_shk_0_dst_valid <= 1'b0;
            m_shk_0_dst_msync <= 1'b0;
            m_shk_0_dst_mdata <= '0;
            m_shk_0_dst_maddr <= '0;
        end else begin
            m_shk_0_dst_valid <= dst_valid_nxt;
            if (load) begin
                m_shk_0_dst_msync <= src_msync[pick_idx];
                m_shk_0_dst_mdata <= src_mdata[pick_idx];
                m_shk_0_dst_maddr <= src_maddr[pick_idx];
            end
        end
    end

    // Sticky error word; a new error in the clear cycle is still recorded.
    always_ff @(posedge i_sys_clk or negedge i_sys_resetn) begin
        if (!i_sys_resetn) begin
            r_err_bits <= 2'b00;
            r_err_idx  <= 2'b00;
        end else if (err_rdy || err_rel) begin
            r_err_bits <= (i_err_clr ? 2'b00 : r_err_bits) | {err_rel, err_rdy};
            r_err_idx  <= r_grant;
        end else if (i_err_clr) begin
            r_err_bits <= 2'b00;
            r_err_idx  <= 2'b00;
        end
    end

    assign m_err_shk_info1 = WD_ERR_INFO'({r_err_idx, r_err_bits});

    // Response only reaches the granted requester while the request is live.
    assign rsp_en = (state == S_REQ) || (state == S_ACK);
    assign sel    = {rsp_en && (r_grant == 2'd3), rsp_en && (r_grant == 2'd2),
                     rsp_en && (r_grant == 2'd1), rsp_en && (r_grant == 2'd0)};

    assign s_shk_0_src_ready = sel[0] & m_shk_0_dst_ready;
    assign s_shk_0_src_ssync = sel[0] & m_shk_0_dst_ssync;
    assign s_shk_0_src_sdata = sel[0] ? m_shk_0_dst_sdata : '0;
    assign s_shk_0_src_saddr = sel[0] ? m_shk_0_dst_saddr : '0;
    assign s_shk_1_src_ready = sel[1] & m_shk_0_dst_ready;
    assign s_shk_1_src_ssync = sel[1] & m_shk_0_dst_ssync;
    assign s_shk_1_src_sdata = sel[1] ? m_shk_0_dst_sdata : '0;
    assign s_shk_1_src_saddr = sel[1] ? m_shk_0_dst_saddr : '0;
    assign s_shk_2_src_ready = sel[2] & m_shk_0_dst_ready;
    assign s_shk_2_src_ssync = sel[2] & m_shk_0_dst_ssync;
    assign s_shk_2_src_sdata = sel[2] ? m_shk_0_dst_sdata : '0;
    assign s_shk_2_src_saddr = sel[2] ? m_shk_0_dst_saddr : '0;
    assign s_shk_3_src_ready = sel[3] & m_shk_0_dst_ready;
    assign s_shk_3_src_ssync = sel[3] & m_shk_0_dst_ssync;
    assign s_shk_3_src_sdata = sel[3] ? m_shk_0_dst_sdata : '0;
    assign s_shk_3_src_saddr = sel[3] ? m_shk_0_dst_saddr : '0;

endmodule

// File: tb/tb_shk_rr_scheduler.sv
// Bench for shk_rr_scheduler: behavioural masters and target, scoreboard of
// expected grant payloads, table of single transactions, corner sequences.
module tb_shk_rr_scheduler;
    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  m_vld, m_sync, m_hold;
    logic [15:0] m_data [4];
    logic [15:0] m_addr [4];
    logic [3:0]  s_rdy, s_ssync;
    logic [15:0] s_sdata [4];
    logic [15:0] s_saddr [4];
    logic        dv, dsync;
    logic [15:0] dmdata, dmaddr;
    logic        t_rdy, t_ssync;
    logic [15:0] t_sdata, t_saddr;
    logic        err_clr;
    logic [3:0]  err;

    typedef struct {
        int          k;
        logic        sync;
        logic [15:0] data;
        logic [15:0] addr;
    } txn_t;

    typedef struct {
        int          k;
        logic        sync;
        logic [15:0] data;
        logic [15:0] addr;
        logic        rsync;
        logic [15:0] rdata;
        logic [15:0] raddr;
        logic [1:0]  ptr;
    } vec_t;

    txn_t q[$];
    txn_t cur;
    vec_t vt [4];
    int   m_rem [4];
    int   tgt_mode, tgt_dly, exp_len, dv_len;
    int   n_tests, n_fail;
    logic prev_dv;
    bit   fell;

    always #5 clk = ~clk;

    shk_rr_scheduler #(.MD_SIM_ABLE(1), .WD_SHK0_DATA(16), .WD_SHK0_ADDR(16),
                       .WD_ERR_INFO(4), .TM_TIMEOUT(TMO)) dut (
        .i_sys_clk(clk), .i_sys_resetn(rst_n),
        .s_shk_0_src_valid(m_vld[0]), .s_shk_0_src_msync(m_sync[0]),
        .s_shk_0_src_mdata(m_data[0]), .s_shk_0_src_maddr(m_addr[0]),
        .s_shk_0_src_ready(s_rdy[0]), .s_shk_0_src_ssync(s_ssync[0]),
        .s_shk_0_src_sdata(s_sdata[0]), .s_shk_0_src_saddr(s_saddr[0]),
        .s_shk_1_src_valid(m_vld[1]), .s_shk_1_src_msync(m_sync[1]),
        .s_shk_1_src_mdata(m_data[1]), .s_shk_1_src_maddr(m_addr[1]),
        .s_shk_1_src_ready(s_rdy[1]), .s_shk_1_src_ssync(s_ssync[1]),
        .s_shk_1_src_sdata(s_sdata[1]), .s_shk_1_src_saddr(s_saddr[1]),
        .s_shk_2_src_valid(m_vld[2]), .s_shk_2_src_msync(m_sync[2]),
        .s_shk_2_src_mdata(m_data[2]), .s_shk_2_src_maddr(m_addr[2]),
        .s_shk_2_src_ready(s_rdy[2]), .s_shk_2_src_ssync(s_ssync[2]),
        .s_shk_2_src_sdata(s_sdata[2]), .s_shk_2_src_saddr(s_saddr[2]),
        .s_shk_3_src_valid(m_vld[3]), .s_shk_3_src_msync(m_sync[3]),
        .s_shk_3_src_mdata(m_data[3]), .s_shk_3_src_maddr(m_addr[3]),
        .s_shk_3_src_ready(s_rdy[3]), .s_shk_3_src_ssync(s_ssync[3]),
        .s_shk_3_src_sdata(s_sdata[3]), .s_shk_3_src_saddr(s_saddr[3]),
        .m_shk_0_dst_valid(dv), .m_shk_0_dst_msync(dsync),
        .m_shk_0_dst_mdata(dmdata), .m_shk_0_dst_maddr(dmaddr),
        .m_shk_0_dst_ready(t_rdy), .m_shk_0_dst_ssync(t_ssync),
        .m_shk_0_dst_sdata(t_sdata), .m_shk_0_dst_saddr(t_saddr),
        .i_err_clr(err_clr), .m_err_shk_info1(err)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic chk_route();
        for (int k = 0; k < 4; k++) begin
            logic [33:0] act, exp;
            act = {s_rdy[k], s_ssync[k], s_sdata[k], s_saddr[k]};
            exp = (dv === 1'b1 && cur.k == k) ? {t_rdy, t_ssync, t_sdata, t_saddr} : 34'd0;
            chk($sformatf("route_%0d", k), 64'(act), 64'(exp));
        end
    endtask

    task automatic raise(input int k);
        txn_t t;
        m_vld[k] = 1'b1;
        t.k = k; t.sync = m_sync[k]; t.data = m_data[k]; t.addr = m_addr[k];
        q.push_back(t);
    endtask

    // One clock: monitor/scoreboard, then master and target models.
    task automatic cycle();
        logic [3:0] r;
        @(posedge clk);
        #1;
        fell = 1'b0;
        if (dv && !prev_dv) begin
            if (q.size() == 0) begin
                n_tests++; n_fail++;
                $display("FAIL unexpected_grant: dst_valid rose with maddr %h, expected no grant", dmaddr);
            end else begin
                cur = q.pop_front();
            end
            dv_len = 0;
        end
        if (dv) begin
            dv_len++;
            chk("dst_payload", 64'({dsync, dmdata, dmaddr}), 64'({cur.sync, cur.data, cur.addr}));
        end
        if (!dv && prev_dv) begin
            fell = 1'b1;
            if (exp_len > 0) chk("valid_len", 64'(dv_len), 64'(exp_len));
        end
        prev_dv = dv;
        chk_route();
        r = s_rdy;
        for (int k = 0; k < 4; k++) begin
            if (m_vld[k] && r[k] && !m_hold[k]) begin
                m_vld[k] = 1'b0;
                m_rem[k]--;
                m_addr[k] = m_addr[k] + 16'd1;
            end else if (!m_vld[k] && !r[k] && m_rem[k] > 0) begin
                raise(k);
            end
        end
        case (tgt_mode)
            1: t_rdy = 1'b0;
            2: if (dv) t_rdy = 1'b1;
            default: begin
                if (dv && !t_rdy) begin
                    if (tgt_dly > 0) tgt_dly--;
                    else t_rdy = 1'b1;
                end else if (!dv && t_rdy) begin
                    t_rdy = 1'b0;
                end
            end
        endcase
        #1;
        chk_route();
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic wait_fall(input int max, input string name);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!fell && n < max);
        if (!fell) begin
            n_tests++; n_fail++;
            $display("FAIL %s: dst_valid did not fall within %0d cycles, required a completed transaction", name, max);
        end
    endtask

    task automatic set_m(input int k, input logic s, input logic [15:0] d, input logic [15:0] a);
        m_sync[k] = s; m_data[k] = d; m_addr[k] = a; m_rem[k] = 1;
    endtask

    initial begin
        vt[0] = '{2, 1'b0, 16'hA5A5, 16'h0010, 1'b0, 16'h1234, 16'h0000, 2'd3};
        vt[1] = '{0, 1'b1, 16'hFFFF, 16'h0000, 1'b1, 16'h0000, 16'hFFFF, 2'd1};
        vt[2] = '{3, 1'b1, 16'h0001, 16'h8000, 1'b1, 16'h5A5A, 16'h00FF, 2'd0};
        vt[3] = '{1, 1'b0, 16'h1357, 16'h2468, 1'b0, 16'hFFFF, 16'hFFFF, 2'd2};

        n_tests = 0; n_fail = 0; prev_dv = 1'b0; dv_len = 0; exp_len = 2;
        tgt_mode = 0; tgt_dly = 0; cur.k = 0;
        rst_n = 1'b0; err_clr = 1'b0; m_vld = 4'h0; m_hold = 4'h0; m_sync = 4'b0101;
        t_rdy = 1'b0; t_ssync = 1'b1; t_sdata = 16'h0BAD; t_saddr = 16'h0C0D;
        for (int k = 0; k < 4; k++) begin
            m_data[k] = 16'hC000 + 16'(k);
            m_addr[k] = 16'h0100 * 16'(k);
            m_rem[k]  = (k == 0) ? 2 : 1;
        end
        // All four pending from reset: grant order 0,1,2,3,0.
        for (int k = 0; k < 4; k++) raise(k);
        #3;
        chk("rst_dst", 64'({dv, dsync, dmdata, dmaddr}), 64'(0));
        chk("rst_err", 64'(err), 64'(0));
        chk("rst_src_ready", 64'(s_rdy), 64'(0));
        #9;
        rst_n = 1'b1;
        begin
            int n;
            n = 0;
            do begin
                cycle();
                n++;
            end while (!(m_rem[0] == 0 && m_rem[1] == 0 && m_rem[2] == 0 && m_rem[3] == 0
                         && !dv && q.size() == 0) && n < 80);
        end
        chk("fair_all_granted", 64'(q.size()), 64'(0));
        run(2);
        chk("fair_ptr", 64'(dut.r_ptr), 64'(1));

        // Table of single transactions with distinct payloads/responses.
        for (int i = 0; i < 4; i++) begin
            t_ssync = vt[i].rsync; t_sdata = vt[i].rdata; t_saddr = vt[i].raddr;
            set_m(vt[i].k, vt[i].sync, vt[i].data, vt[i].addr);
            exp_len = 2;
            wait_fall(20, $sformatf("vec_%0d", i));
            run(2);
            chk($sformatf("vec_%0d_ptr", i), 64'(dut.r_ptr), 64'(vt[i].ptr));
        end

        // Requester 1 drops valid in S_REQ while requester 3 waits.
        exp_len = -1; tgt_dly = 3;
        set_m(1, 1'b1, 16'h7E57, 16'h0042);
        cycle();
        cycle();
        m_vld[1] = 1'b0; m_rem[1] = 0; m_data[1] = 16'hDEAD; m_addr[1] = 16'hBEEF;
        set_m(3, 1'b0, 16'h3333, 16'h0303);
        wait_fall(30, "drop_req1");
        exp_len = 2;
        wait_fall(20, "drop_next3");
        run(2);
        chk("drop_all_granted", 64'(q.size()), 64'(0));

        // Target never ready: ready timeouts for requesters 0 then 1.
        tgt_mode = 1; exp_len = TMO;
        set_m(0, 1'b0, 16'h0F0F, 16'h0A00);
        set_m(1, 1'b1, 16'hF0F0, 16'h0A01);
        wait_fall(40, "tmo_0");
        chk("tmo_0_err", 64'(err), 64'(4'b0001));
        wait_fall(40, "tmo_1");
        chk("tmo_1_err", 64'(err), 64'(4'b0101));
        m_vld = 4'h0;
        for (int k = 0; k < 4; k++) m_rem[k] = 0;
        run(3);
        chk("tmo_all_granted", 64'(q.size()), 64'(0));
        err_clr = 1'b1;
        cycle();
        err_clr = 1'b0;
        chk("err_clear_1", 64'(err), 64'(0));

        // Target holds ready after valid drops: release timeout.
        tgt_mode = 2; exp_len = 2;
        set_m(3, 1'b1, 16'h4444, 16'h0404);
        wait_fall(20, "rel_3");
        chk("done_ready_masked", 64'(s_rdy), 64'(0));
        run(TMO - 1);
        chk("rel_err_before", 64'(err), 64'(0));
        cycle();
        chk("rel_err", 64'(err), 64'(4'b1110));
        chk("rel_ptr", 64'(dut.r_ptr), 64'(0));
        tgt_mode = 0;
        run(2);

        // Reset while in S_ACK, after moving r_ptr away from 0.
        set_m(1, 1'b0, 16'h1111, 16'h0101);
        wait_fall(20, "pre_rst_1");
        run(2);
        exp_len = -1; m_hold[2] = 1'b1;
        set_m(2, 1'b1, 16'h2222, 16'h0202);
        run(3);
        chk("ack_ready", 64'(s_rdy), 64'(4'b0100));
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_dst", 64'({dv, dsync, dmdata, dmaddr}), 64'(0));
        chk("arst_err", 64'(err), 64'(0));
        chk("arst_src", 64'({s_rdy, s_ssync, s_sdata[2], s_saddr[2]}), 64'(0));
        t_rdy = 1'b0; m_hold = 4'h0; m_vld = 4'h0; q.delete(); prev_dv = 1'b0;
        for (int k = 0; k < 4; k++) m_rem[k] = 0;
        #10;
        rst_n = 1'b1;
        exp_len = 2;
        set_m(0, 1'b1, 16'h5050, 16'h0500);
        set_m(2, 1'b0, 16'h5252, 16'h0502);
        wait_fall(20, "post_rst_0");
        wait_fall(20, "post_rst_2");
        run(2);
        chk("post_rst_all_granted", 64'(q.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench still running at 500us, required completion");
        $fatal(1);
    end

endmodule
